sram_line_fifo_ctrl: RTL and testbench
======================================

# sram_line_fifo_ctrl

Streaming FIFO controller for the 512-bit x 16-word, one-write/one-read-port OpenRAM macro. It turns the macro into a valid/ready line FIFO: it drives the write-port strobes from the push interface and the read-port strobes from its own prefetch logic. It captures the macro's read data into a 2-entry output skid buffer, so pop-side back-pressure never has to stall the macro. It sits between a cache-line producer and consumer; both macro clocks are tied to `clk_i` outside this block.

## Interface
- `DATA_WIDTH`, 512: line width; equals the macro word size.
- `ADDR_WIDTH`, 4: macro address width.
- `DEPTH`, `1 << ADDR_WIDTH`: macro entries (16).
- `clk_i`  in  1  single clock for the block and both macro ports.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `flush_i`  in  1  synchronous clear of all contents.
- `push_valid_i`  in  1  push request.
- `push_ready_o`  out  1  push accepted when `push_valid_i & push_ready_o`.
- `push_data_i`  in  DATA_WIDTH  push line.
- `pop_valid_o`  out  1  head line valid.
- `pop_ready_i`  in  1  consumer takes the head line.
- `pop_data_o`  out  DATA_WIDTH  head line.
- `sram_csb0_o`  out  1  macro write chip select, active low.
- `sram_addr0_o`  out  ADDR_WIDTH  macro write address.
- `sram_din0_o`  out  DATA_WIDTH  macro write data.
- `sram_csb1_o`  out  1  macro read chip select, active low.
- `sram_addr1_o`  out  ADDR_WIDTH  macro read address.
- `sram_dout1_i`  in  DATA_WIDTH  macro read data; valid at the clock edge after the read is issued.
- `level_o`  out  ADDR_WIDTH+2  total lines held (0..DEPTH+2).

## Operation
- State:
  - `wr_ptr`, `rd_ptr`: ADDR_WIDTH+1 bits each, with a wrap bit.
  - `sram_cnt = wr_ptr - rd_ptr` (0..DEPTH).
  - `inflight_q`: 1 bit.
  - Output buffer: 2 registers plus `occ` (0..2).
  - `active_q`: cleared by reset, set on the first edge after reset.
- Push:
  - `push_ready_o = active_q & ~flush_i & (sram_cnt < DEPTH)`. It depends on registers only, not on pop activity.
  - On a push fire: `sram_csb0_o=0`, `sram_addr0_o=wr_ptr[ADDR_WIDTH-1:0]`, `sram_din0_o=push_data_i` (combinational). `wr_ptr` increments at the edge.
  - `sram_csb0_o=1` otherwise.
- Read issue (`rd_go`):
  - Condition: `~flush_i & sram_cnt != 0 & (occ + inflight_q - pop_fire) < 2`.
  - `pop_fire = pop_valid_o & pop_ready_i`.
  - `sram_cnt` uses registered pointers, so a push in the same cycle never counts toward it.
  - On `rd_go`: `sram_csb1_o=0`, `sram_addr1_o=rd_ptr` low bits. `rd_ptr` increments and `inflight_q<=1`.
  - Otherwise `sram_csb1_o=1` and `inflight_q<=0`.
- Capture: when `inflight_q=1`, `sram_dout1_i` is written into the buffer tail at the edge.
- Output buffer:
  - `pop_valid_o = (occ != 0)`; `pop_data_o` is the head register.
  - On `pop_fire` the head advances.
  - A capture and a pop in the same cycle keep `occ` unchanged.
- Collision freedom: a read never targets the write address of the same cycle. A read needs `sram_cnt > 0`, so `rd_ptr` differs from `wr_ptr`. Equal low bits imply full, and then `push_ready_o=0`.
- `level_o = sram_cnt + inflight_q + occ`. Capacity is DEPTH+2 = 18.
- Flush: at the edge, pointers, `inflight_q` and `occ` clear; buffer data is not cleared. Any in-flight read data is discarded. The flush cycle itself issues no macro access and accepts no push.
- Reset values:
  - Pointers, `inflight_q`, `occ`, `active_q` = 0; buffer registers = 0.
  - Outputs: `push_ready_o=0`, `pop_valid_o=0`, `pop_data_o=0`, `sram_csb0_o=1`, `sram_csb1_o=1`, `level_o=0`.
  - Addresses read as 0 while idle.
- An asynchronous reset mid-operation discards all contents immediately. Macro contents are left stale and are never read, because the pointers restart at 0.

## Timing
- The first push is possible in the second cycle after `rst_ni` rises.
- Push fire at edge E → read issued in the cycle after E → captured at E+2 → `pop_valid_o` high after E+2. Push-to-pop latency is 2 cycles.
- Sustained throughput is 1 line/cycle in and out when `pop_ready_i=1` continuously.
- `push_ready_o` falls in the cycle after the edge where `sram_cnt` reaches DEPTH. It rises in the cycle after the edge where a read issue reduces `sram_cnt`.
- Combinational paths: `pop_ready_i` → `sram_csb1_o`; `push_valid_i` → `sram_csb0_o`. No path from `pop_ready_i` to `push_ready_o`.

## Test plan
- Reset: hold `rst_ni=0` with `push_valid_i=1` → `sram_csb0_o=1`, `sram_csb1_o=1`, `push_ready_o=0`, `pop_valid_o=0`, `level_o=0`. One cycle after release, `push_ready_o=1`.
- Single line: push `512'hA5` at edge E → `sram_csb1_o=0`, `addr1=0` in the next cycle → `pop_valid_o=1`, `pop_data_o=512'hA5` after E+2.
- Fill: `pop_ready_i=0`, push lines 0..17 back-to-back → `level_o` reaches 18 and `push_ready_o=0`, with `occ=2` and `sram_cnt=16`. Then pop all → values 0..17 in order and `level_o=0`.
- Streaming and wrap: 40 back-to-back lines with `pop_ready_i=1` → one pop per cycle after 2-cycle latency, in order, with addresses wrapping 15→0. The write and read addresses are never equal in a cycle where both chip selects are low.
- Back-pressure: toggle `pop_ready_i` randomly while pushing 100 incrementing lines → no loss, no duplication, and `level_o` always equals pushes minus pops.
- Flush or reset mid-stream: with 10 lines held and a read in flight, assert `flush_i` (or pulse `rst_ni` low) → `level_o=0` and `pop_valid_o=0` on the next cycle. Push `512'h1` → it pops as the first line; no stale data appears.

Source files
------------

// File: rtl/sram_line_fifo_ctrl.sv
// sram_line_fifo_ctrl: valid/ready line FIFO built around a 1W/1R SRAM macro.
// The write port is driven directly from the push handshake. The read port is
// driven by prefetch logic that keeps a 2-entry output buffer topped up, so the
// consumer can stall without ever stalling the macro.
module sram_line_fifo_ctrl #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  push_valid_i,
    output logic                  push_ready_o,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    output logic                  pop_valid_o,
    input  logic                  pop_ready_i,
    output logic [DATA_WIDTH-1:0] pop_data_o,
    output logic                  sram_csb0_o,
    output logic [ADDR_WIDTH-1:0] sram_addr0_o,
    output logic [DATA_WIDTH-1:0] sram_din0_o,
    output logic                  sram_csb1_o,
    output logic [ADDR_WIDTH-1:0] sram_addr1_o,
    input  logic [DATA_WIDTH-1:0] sram_dout1_i,
    output logic [ADDR_WIDTH+1:0] level_o
);

    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam int LVL_W = ADDR_WIDTH + 2;

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      sram_cnt;
    logic                  inflight_q;
    logic                  active_q;
    logic                  head_q;
    logic [1:0]            occ;
    logic [2:0]            occ_next;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic                  push_fire;
    logic                  pop_fire;
    logic                  rd_go;

    // Pointers carry a wrap bit, so the difference is the macro fill 0..DEPTH.
    assign sram_cnt  = wr_ptr - rd_ptr;

    // Push readiness looks only at registers; pop activity never reaches it.
    assign push_ready_o = active_q & ~flush_i & (sram_cnt < PTR_W'(DEPTH));
    assign push_fire    = push_valid_i & push_ready_o;

    assign pop_valid_o = (occ != 2'd0);
    assign pop_fire    = pop_valid_o & pop_ready_i;
    assign pop_data_o  = buf_q[head_q];

    // Buffer occupancy after this edge: the in-flight read lands, a pop leaves.
    // A new read is only issued if its data will find a free slot next edge.
    assign occ_next = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop_fire};
    assign rd_go    = ~flush_i & (sram_cnt != '0) & (occ_next < 3'd2);

    // A read needs a non-empty macro, so rd_ptr != wr_ptr; equal low bits then
    // mean full, where no push is accepted -- the ports never collide.
    assign sram_csb0_o  = ~push_fire;
    assign sram_addr0_o = push_fire ? wr_ptr[ADDR_WIDTH-1:0] : '0;
    assign sram_din0_o  = push_data_i;
    assign sram_csb1_o  = ~rd_go;
    assign sram_addr1_o = rd_go ? rd_ptr[ADDR_WIDTH-1:0] : '0;

    assign level_o = LVL_W'(sram_cnt) + LVL_W'(inflight_q) + LVL_W'(occ);

    // Control state: pointers, read-in-flight flag, buffer occupancy and head.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            inflight_q <= 1'b0;
            occ        <= 2'd0;
            head_q     <= 1'b0;
        end else begin
            active_q <= 1'b1;
            if (flush_i) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                inflight_q <= 1'b0;
                occ        <= 2'd0;
                head_q     <= 1'b0;
            end else begin
                if (push_fire) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (rd_go) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                inflight_q <= rd_go;
                occ        <= occ_next[1:0];
                if (pop_fire) begin
                    head_q <= ~head_q;
                end
            end
        end
    end

    // Capture returning read data into the buffer tail; a flush drops it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else if (inflight_q && !flush_i) begin
            buf_q[head_q ^ occ[0]] <= sram_dout1_i;
        end
    end

endmodule

// File: tb/tb_sram_line_fifo_ctrl.sv
// tb_sram_line_fifo_ctrl: directed vector table, corner-case sequences and
// randomized back-pressure, checked against a line-queue reference model.
module tb_sram_line_fifo_ctrl;

    localparam int DW = 512;
    localparam int AW = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          flush_i = 1'b0;
    logic          push_valid_i = 1'b0;
    logic          push_ready_o;
    logic [DW-1:0] push_data_i = '0;
    logic          pop_valid_o;
    logic          pop_ready_i = 1'b0;
    logic [DW-1:0] pop_data_o;
    logic          sram_csb0_o;
    logic [AW-1:0] sram_addr0_o;
    logic [DW-1:0] sram_din0_o;
    logic          sram_csb1_o;
    logic [AW-1:0] sram_addr1_o;
    logic [DW-1:0] sram_dout1_i;
    logic [AW+1:0] level_o;

    int n_vec = 0;
    int n_mis = 0;
    int pop_cnt = 0;
    int cyc = 0;
    bit sb_en = 1'b0;
    bit bp_done = 1'b0;
    logic [DW-1:0] last_pop = '0;
    logic [DW-1:0] mq[$];
    logic [DW-1:0] mem [1 << AW];

    sram_line_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .push_valid_i (push_valid_i),
        .push_ready_o (push_ready_o),
        .push_data_i  (push_data_i),
        .pop_valid_o  (pop_valid_o),
        .pop_ready_i  (pop_ready_i),
        .pop_data_o   (pop_data_o),
        .sram_csb0_o  (sram_csb0_o),
        .sram_addr0_o (sram_addr0_o),
        .sram_din0_o  (sram_din0_o),
        .sram_csb1_o  (sram_csb1_o),
        .sram_addr1_o (sram_addr1_o),
        .sram_dout1_i (sram_dout1_i),
        .level_o      (level_o)
    );

    always #5 clk_i = ~clk_i;

    // Macro model: synchronous write, read data valid after the issuing edge.
    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (!sram_csb0_o) mem[sram_addr0_o] <= sram_din0_o;
        if (!sram_csb1_o) sram_dout1_i <= mem[sram_addr1_o];
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: the FIFO is an ordered list of held lines.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            mq.delete();
            if (sb_en) begin
                chk("rst_level", DW'(level_o), DW'(0));
                chk("rst_pop_valid", DW'(pop_valid_o), DW'(0));
                chk("rst_push_ready", DW'(push_ready_o), DW'(0));
                chk("rst_csb", DW'({sram_csb0_o, sram_csb1_o}), DW'(2'b11));
            end
        end else if (sb_en) begin
            chk("level", DW'(level_o), DW'(mq.size()));
            if (!sram_csb0_o && !sram_csb1_o && sram_addr0_o == sram_addr1_o) begin
                chk("addr_collision", DW'(sram_addr1_o), DW'(~sram_addr0_o));
            end
            if (flush_i) chk("flush_push_ready", DW'(push_ready_o), DW'(0));
            if (pop_valid_o && pop_ready_i) begin
                if (mq.size() == 0) begin
                    chk("pop_from_empty", DW'(pop_valid_o), DW'(0));
                end else begin
                    chk("pop_data", pop_data_o, mq[0]);
                    last_pop = mq[0];
                    void'(mq.pop_front());
                end
                pop_cnt++;
            end
            if (push_valid_i && push_ready_o) mq.push_back(push_data_i);
            if (flush_i) mq.delete();
        end
    end

    typedef struct {
        logic          rn, pv, pr, fl;
        logic [DW-1:0] d;
        logic          e_prdy, e_pvld, e_csb0, e_csb1;
        logic [5:0]    e_lvl;
        logic          cd;
        logic [DW-1:0] ed;
        logic          ca;
        logic [AW-1:0] ea;
    } vec_t;

    function automatic vec_t mk(logic rn, logic pv, logic pr, logic fl, logic [DW-1:0] d,
                                logic e_prdy, logic e_pvld, logic e_csb0, logic e_csb1,
                                logic [5:0] e_lvl, logic cd, logic [DW-1:0] ed,
                                logic ca, logic [AW-1:0] ea);
        vec_t v;
        v.rn = rn; v.pv = pv; v.pr = pr; v.fl = fl; v.d = d;
        v.e_prdy = e_prdy; v.e_pvld = e_pvld; v.e_csb0 = e_csb0; v.e_csb1 = e_csb1;
        v.e_lvl = e_lvl; v.cd = cd; v.ed = ed; v.ca = ca; v.ea = ea;
        return v;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0; push_valid_i = 1'b0; pop_ready_i = 1'b0; flush_i = 1'b0;
        step(); step();
        rst_ni = 1'b1;
        step();
    endtask

    task automatic push_line(input logic [DW-1:0] d);
        bit ok = 1'b0;
        push_valid_i = 1'b1;
        push_data_i  = d;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk_i);
            if (push_ready_o) begin ok = 1'b1; break; end
        end
        if (!ok) chk("push_timeout", DW'(0), DW'(1));
        step();
        push_valid_i = 1'b0;
    endtask

    task automatic drain();
        step();
        pop_ready_i = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk_i);
            if (level_o == '0 && !pop_valid_o) break;
        end
        chk("drain_level", DW'(level_o), DW'(0));
        chk("drain_pop_valid", DW'(pop_valid_o), DW'(0));
        step();
        pop_ready_i = 1'b0;
    endtask

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] r;
        for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic hold_then_break(input bit use_reset);
        for (int i = 0; i < 10; i++) push_line(DW'(i + 200));
        step(); step(); step();
        pop_ready_i = 1'b1;
        step();
        pop_ready_i = 1'b0;
        if (use_reset) begin
            @(negedge clk_i);
            chk("pre_reset_level", DW'(level_o), DW'(9));
            step();
            rst_ni = 1'b0;
            step();
            rst_ni = 1'b1;
        end else begin
            flush_i = 1'b1;
            push_valid_i = 1'b1;
            push_data_i = DW'(32'hDEAD);
            @(negedge clk_i);
            chk("flush_pre_level", DW'(level_o), DW'(9));
            chk("flush_csb", DW'({sram_csb0_o, sram_csb1_o}), DW'(2'b11));
            step();
            flush_i = 1'b0;
            push_valid_i = 1'b0;
        end
        @(negedge clk_i);
        chk("after_break_level", DW'(level_o), DW'(0));
        chk("after_break_pop_valid", DW'(pop_valid_o), DW'(0));
        step();
        push_line(DW'(1));
        drain();
        chk("first_after_break", last_pop, DW'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        int pc0, t0;
        // rst pv pr fl data | prdy pvld csb0 csb1 lvl | chk_data data | chk_a1 a1
        vecs.push_back(mk(0, 1, 0, 0, DW'(8'hA5), 0, 0, 1, 1, 0, 1, DW'(0), 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, DW'(8'hA5), 0, 0, 1, 1, 0, 1, DW'(0), 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, DW'(8'hA5), 1, 0, 0, 1, 0, 0, DW'(0), 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, DW'(0),     1, 0, 1, 0, 1, 0, DW'(0), 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, DW'(0),     1, 0, 1, 1, 1, 0, DW'(0), 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, DW'(0),     1, 1, 1, 1, 1, 1, DW'(8'hA5), 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, DW'(0),     1, 0, 1, 1, 0, 0, DW'(0), 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, DW'(8'h3C), 1, 0, 0, 1, 0, 0, DW'(0), 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, DW'(0),     0, 0, 1, 1, 1, 0, DW'(0), 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, DW'(0),     1, 0, 1, 1, 0, 0, DW'(0), 0, 0));

        step(); step();
        foreach (vecs[i]) begin
            rst_ni = vecs[i].rn; push_valid_i = vecs[i].pv; pop_ready_i = vecs[i].pr;
            flush_i = vecs[i].fl; push_data_i = vecs[i].d;
            @(negedge clk_i);
            chk($sformatf("v%0d_push_ready", i), DW'(push_ready_o), DW'(vecs[i].e_prdy));
            chk($sformatf("v%0d_pop_valid", i), DW'(pop_valid_o), DW'(vecs[i].e_pvld));
            chk($sformatf("v%0d_csb0", i), DW'(sram_csb0_o), DW'(vecs[i].e_csb0));
            chk($sformatf("v%0d_csb1", i), DW'(sram_csb1_o), DW'(vecs[i].e_csb1));
            chk($sformatf("v%0d_level", i), DW'(level_o), DW'(vecs[i].e_lvl));
            if (vecs[i].cd) chk($sformatf("v%0d_pop_data", i), pop_data_o, vecs[i].ed);
            if (vecs[i].ca) chk($sformatf("v%0d_addr1", i), DW'(sram_addr1_o), DW'(vecs[i].ea));
            step();
        end
        push_valid_i = 1'b0; pop_ready_i = 1'b0; flush_i = 1'b0;

        sb_en = 1'b1;

        // Fill to capacity with the consumer stalled, then drain in order.
        do_reset();
        for (int i = 0; i < 18; i++) push_line(DW'(i));
        step(); step(); step();
        @(negedge clk_i);
        chk("fill_level", DW'(level_o), DW'(18));
        chk("fill_push_ready", DW'(push_ready_o), DW'(0));
        chk("fill_pop_valid", DW'(pop_valid_o), DW'(1));
        drain();
        chk("fill_last", last_pop, DW'(17));

        // Streaming at full rate across the address wrap.
        do_reset();
        pop_ready_i = 1'b1;
        pc0 = pop_cnt;
        t0 = cyc;
        for (int i = 0; i < 40; i++) push_line(rand_line());
        chk("stream_push_cycles", DW'(cyc - t0), DW'(40));
        step(); step(); step();
        chk("stream_pops", DW'(pop_cnt - pc0), DW'(40));
        drain();

        // Random back-pressure with random push gaps.
        do_reset();
        pc0 = pop_cnt;
        bp_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    if ($urandom_range(3) == 0) step();
                    push_line(DW'(i + 1000));
                end
                bp_done = 1'b1;
            end
            begin
                while (!bp_done) begin
                    pop_ready_i = 1'($urandom_range(1));
                    step();
                end
            end
        join
        drain();
        chk("bp_pops", DW'(pop_cnt - pc0), DW'(100));
        chk("bp_last", last_pop, DW'(1099));

        // Flush, then reset, with lines held and a read in flight.
        do_reset();
        hold_then_break(1'b0);
        do_reset();
        hold_then_break(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
